// File: rtl/sram_seq_ctrl.sv
// Clocked sequencer for an asynchronous SRAM on a shared bidirectional data bus.
// Runs one read or write per accepted request with setup, strobe, hold and turnaround phases.
module sram_seq_ctrl #(
   parameter int DW        = 4,
   parameter int AW        = 4,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int TURN_CYC  = 1
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          REQ,
   input  logic          WE,
   input  logic [AW-1:0] ADDR,
   input  logic [DW-1:0] WDATA,
   output logic          BUSY,
   output logic          DONE,
   output logic [DW-1:0] RDATA,
   output logic          nCS,
   output logic          nWE,
   output logic          nOE,
   output logic [AW-1:0] A,
   inout  wire  [DW-1:0] D
);

   localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAXC   = (MAX_SP > TURN_CYC) ? MAX_SP : TURN_CYC;
   localparam int CW     = $clog2(MAXC) + 1;

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] TURN_LD  = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

   typedef enum logic [2:0] {
      IDLE, SETUP, WSTRB, WHOLD, RSTRB, RDONE, TURN
   } state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          we_q;
   logic          drive_q;
   logic [DW-1:0] dout_q;
   logic          busy_q;
   logic          done_q;
   logic [DW-1:0] rdata_q;
   logic          ncs_q;
   logic          nwe_q;
   logic          noe_q;
   logic [AW-1:0] a_q;

   // The bus enable is a register, so reset releases D asynchronously with the strobes.
   assign D     = drive_q ? dout_q : 'z;
   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign RDATA = rdata_q;
   assign nCS   = ncs_q;
   assign nWE   = nwe_q;
   assign nOE   = noe_q;
   assign A     = a_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         drive_q <= 1'b0;
         dout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         ncs_q   <= 1'b1;
         nwe_q   <= 1'b1;
         noe_q   <= 1'b1;
         a_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (REQ) begin
                  state_q <= SETUP;
                  cnt_q   <= SETUP_LD;
                  we_q    <= WE;
                  a_q     <= ADDR;
                  dout_q  <= WDATA;
                  drive_q <= WE;
                  ncs_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            SETUP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  cnt_q <= PULSE_LD;
                  if (we_q) begin
                     state_q <= WSTRB;
                     nwe_q   <= 1'b0;
                  end else begin
                     state_q <= RSTRB;
                     noe_q   <= 1'b0;
                  end
               end
            end
            WSTRB: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  state_q <= WHOLD;
                  nwe_q   <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            WHOLD: begin
               state_q <= IDLE;
               ncs_q   <= 1'b1;
               drive_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            RSTRB: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  state_q <= RDONE;
                  noe_q   <= 1'b1;
                  ncs_q   <= 1'b1;
                  done_q  <= 1'b1;
                  rdata_q <= D;
               end
            end
            RDONE: begin
               if (TURN_CYC > 0) begin
                  state_q <= TURN;
                  cnt_q   <= TURN_LD;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            TURN: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic strobe_low;
   assign strobe_low = !nwe_q || !noe_q;

   a_no_oe_while_driving: assert property (@(posedge CLK) disable iff (!nRST)
      !(!noe_q && drive_q));
   a_no_dual_strobe: assert property (@(posedge CLK) disable iff (!nRST)
      !(!nwe_q && !noe_q));
   a_addr_cs_stable: assert property (@(posedge CLK) disable iff (!nRST)
      (strobe_low && $past(strobe_low)) |-> ($stable(a_q) && $stable(ncs_q)));
   a_wdata_stable: assert property (@(posedge CLK) disable iff (!nRST)
      (state_q inside {WSTRB, WHOLD}) |-> (drive_q && $stable(dout_q)));

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Directed bench for sram_seq_ctrl against a small 16x4 asynchronous SRAM model.
// An undriven data bus floats to 4'hF through pull-ups, which makes bus release observable.
module tb_sram_seq_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       REQ;
   logic       WE;
   logic [3:0] ADDR;
   logic [3:0] WDATA;
   logic       BUSY;
   logic       DONE;
   logic [3:0] RDATA;
   logic       nCS;
   logic       nWE;
   logic       nOE;
   logic [3:0] A;
   wire  [3:0] d_bus;

   int n_checks = 0;
   int n_pass   = 0;

   sram_seq_ctrl #(
      .DW(4), .AW(4), .SETUP_CYC(1), .PULSE_CYC(2), .TURN_CYC(1)
   ) dut (
      .CLK(CLK), .nRST(nRST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
      .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .nCS(nCS), .nWE(nWE), .nOE(nOE),
      .A(A), .D(d_bus)
   );

   always #5 CLK = ~CLK;

   // SRAM model: level-sensitive write sampled mid-cycle, combinational read drive.
   logic [3:0] mem [16] = '{default: 4'h0};
   always @(negedge CLK) if (!nCS && !nWE) mem[A] <= d_bus;
   assign d_bus = (!nCS && !nOE && nWE) ? mem[A] : 4'bzzzz;
   pullup (d_bus[0]);
   pullup (d_bus[1]);
   pullup (d_bus[2]);
   pullup (d_bus[3]);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (BUSY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) check({tag, "_idle_timeout"}, 32'(BUSY), 32'd0);
   endtask

   // Issues one access, checks DONE latency (cycles after the accept edge) and read data.
   task automatic access(input logic we, input logic [3:0] addr, input logic [3:0] wd,
                         input logic [3:0] exp_rd, input string tag);
      int  k = 1;
      bit  seen = 0;
      wait_idle(tag);
      REQ = 1'b1; WE = we; ADDR = addr; WDATA = wd;
      @(negedge CLK);
      REQ = 1'b0;
      while (!seen && k <= 20) begin
         if (DONE) seen = 1;
         else begin
            @(negedge CLK);
            k++;
         end
      end
      check({tag, "_latency"}, 32'(k), 32'd4);
      if (!we) check({tag, "_rdata"}, 32'(RDATA), 32'(exp_rd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b0; REQ = 1'b0; WE = 1'b0; ADDR = 4'h0; WDATA = 4'h0;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_rdata", 32'(RDATA), 32'd0);
      check("rst_ncs", 32'(nCS), 32'd1);
      check("rst_nwe", 32'(nWE), 32'd1);
      check("rst_noe", 32'(nOE), 32'd1);
      check("rst_a", 32'(A), 32'd0);
      check("rst_d_released", 32'(d_bus), 32'hF);

      // Basic write/read with latency
      access(1'b1, 4'h5, 4'hF, 4'h0, "t1_w5");
      access(1'b1, 4'hA, 4'h1, 4'h0, "t1_wA");
      access(1'b0, 4'h5, 4'h0, 4'hF, "t1_r5");
      access(1'b0, 4'hA, 4'h0, 4'h1, "t1_rA");

      // Boundary addresses, other cells untouched
      access(1'b1, 4'h0, 4'h3, 4'h0, "t3_w0");
      access(1'b1, 4'hF, 4'hC, 4'h0, "t3_wF");
      access(1'b0, 4'h0, 4'h0, 4'h3, "t3_r0");
      access(1'b0, 4'hF, 4'h0, 4'hC, "t3_rF");
      access(1'b0, 4'h5, 4'h0, 4'hF, "t3_r5");
      access(1'b0, 4'hA, 4'h0, 4'h1, "t3_rA");

      // Inputs change after acceptance; REQ while busy is dropped
      wait_idle("t4");
      REQ = 1'b1; WE = 1'b1; ADDR = 4'h3; WDATA = 4'h6;
      @(negedge CLK);
      WE = 1'b0; ADDR = 4'h4; WDATA = 4'h9;
      @(negedge CLK);
      check("t4_a_latched", 32'(A), 32'h3);
      check("t4_nwe_low", 32'(nWE), 32'd0);
      check("t4_d_latched", 32'(d_bus), 32'h6);
      @(negedge CLK);
      REQ = 1'b0;
      wait_idle("t4");
      @(negedge CLK);
      check("t4_no_queued_req", 32'(BUSY), 32'd0);
      access(1'b0, 4'h3, 4'h0, 4'h6, "t4_r3");
      access(1'b0, 4'h4, 4'h0, 4'h0, "t4_r4");

      // REQ held high, WE flipped at each DONE: gaps alternate write=5, read=6
      begin
         int   acc = 0, last_k = 0, k = 0, dual = 0;
         logic cur_we = 1'b1;
         logic prev_busy = 1'b0;
         wait_idle("t2");
         REQ = 1'b1; WE = 1'b1; ADDR = 4'h7; WDATA = 4'h9;
         while (acc < 6 && k < 80) begin
            @(negedge CLK);
            k++;
            if (!nWE && !nOE) dual++;
            if (BUSY && !prev_busy) begin
               if (acc > 0) check("t2_gap", 32'(k - last_k), cur_we ? 32'd5 : 32'd6);
               cur_we = WE;
               acc++;
               last_k = k;
            end
            if (DONE) begin
               if (!cur_we) check("t2_rdata", 32'(RDATA), 32'h9);
               WE = !WE;
            end
            prev_busy = BUSY;
         end
         REQ = 1'b0;
         check("t2_accepts", 32'(acc), 32'd6);
         check("t2_dual_strobe", 32'(dual), 32'd0);
      end

      // Reset in the middle of a write strobe
      wait_idle("t5");
      REQ = 1'b1; WE = 1'b1; ADDR = 4'h8; WDATA = 4'h0;
      @(negedge CLK);
      REQ = 1'b0;
      @(negedge CLK);
      check("t5_pre_nwe", 32'(nWE), 32'd0);
      check("t5_pre_d", 32'(d_bus), 32'h0);
      nRST = 1'b0;
      #1;
      check("t5_nwe", 32'(nWE), 32'd1);
      check("t5_ncs", 32'(nCS), 32'd1);
      check("t5_noe", 32'(nOE), 32'd1);
      check("t5_d_released", 32'(d_bus), 32'hF);
      check("t5_busy", 32'(BUSY), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      access(1'b1, 4'h9, 4'h2, 4'h0, "t5_w9");
      access(1'b0, 4'h9, 4'h0, 4'h2, "t5_r9");

      // Read followed by an immediately pending write: turnaround on D
      begin
         int   rise_k = 0, drive_k = 0, wdone_k = 0;
         logic prev_noe = 1'b1;
         wait_idle("t6");
         REQ = 1'b1; WE = 1'b0; ADDR = 4'h5; WDATA = 4'h0;
         for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (k == 1) begin
               WE = 1'b1; ADDR = 4'hE; WDATA = 4'h5;
            end
            if (!prev_noe && nOE && rise_k == 0) rise_k = k;
            if (drive_k == 0 && d_bus == 4'h5) drive_k = k;
            if (k == 4) begin
               check("t6_read_done", 32'(DONE), 32'd1);
               check("t6_rdata", 32'(RDATA), 32'hF);
            end
            if (k == 6) check("t6_idle_gap", 32'(BUSY), 32'd0);
            if (DONE && k > 4 && wdone_k == 0) wdone_k = k;
            if (drive_k != 0) REQ = 1'b0;
            prev_noe = nOE;
         end
         check("t6_noe_rise", 32'(rise_k), 32'd4);
         check("t6_first_drive", 32'(drive_k), 32'd7);
         check("t6_turn_ge2", 32'((drive_k - rise_k) >= 2), 32'd1);
         check("t6_write_done", 32'(wdone_k), 32'd10);
         check("t6_rdata_kept", 32'(RDATA), 32'hF);
      end
      access(1'b0, 4'hE, 4'h0, 4'h5, "t6_rE");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
